ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset, 0xF4 enable) to the keyboard over the same PS2_CLK/PS2_DATA pair the keyboard receive path listens on.
- Implements the host side of the bidirectional protocol: inhibit, request-to-send, bit shifting on device-generated clocks, acknowledge check and timeouts.
- The top level wraps the open-drain lines. Each line is driven low when its `_oe` output is 1, otherwise Z.
- `busy` gates the keyboard receive path off during a transfer.

Parameters:
- INHIBIT_CYC, 12000, cycles clk is held low before the request (120 us at 100 MHz).
- START_TMO_CYC, 1500000, maximum wait for the first device falling edge (15 ms).
- PKT_TMO_CYC, 200000, maximum time from the first falling edge to the ack (2 ms).
- MAX_RETRY, 2, retries after a failure (used only with PS2_TX_RETRY_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_ready=1.
- tx_ready  out  1  idle, can accept a byte.
- busy  out  1  transfer in progress.
- tx_done  out  1  one-cycle pulse: device acked.
- tx_error  out  1  one-cycle pulse: nack or timeout (final).
- ps2_clk_in  in  1  raw PS2_CLK line level.
- ps2_data_in  in  1  raw PS2_DATA line level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.

Behaviour:
- Reset (reset=0):
  - state=IDLE.
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0.
  - tx_ready=1, since it is combinational: state==IDLE.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - fall = (synced clk) previous 1, current 0.
  - The counter, bit_cnt and the shift register are all internal.
- IDLE: when tx_valid && tx_ready, latch the 10-bit frame {1'b1 stop, ~^tx_data odd parity, tx_data}, clear retry_cnt, then go to INHIBIT.
- INHIBIT: clk_oe=1. After INHIBIT_CYC cycles, set data_oe=1 (start bit 0) and go to RTS.
- RTS: exactly one cycle with clk_oe=1, data_oe=1. Then clk_oe=0 and go to WAIT_CLK.
- WAIT_CLK: on the first fall, drive frame bit 0 (data_oe = ~bit), set bit_cnt=1, go to SHIFT. If START_TMO_CYC elapses with no fall, go to FAIL.
- SHIFT: on each fall, drive frame[bit_cnt] and increment bit_cnt.
  - Data bits go out LSB first, then parity.
  - bit_cnt=9 drives the stop bit, i.e. the line is released.
  - A fall with bit_cnt=10 goes to ACK.
- ACK: sample synced data on the 11th fall.
  - The 11th fall is the one that moves SHIFT to ACK, so the sample is taken on that same edge.
  - data==0 goes to WAIT_IDLE; data==1 goes to FAIL.
- PKT_TMO_CYC is measured from the first fall through ACK. If it expires, go to FAIL.
- WAIT_IDLE: wait until synced clk and data are both 1, then pulse tx_done and return to IDLE. This state has no timeout.
- FAIL: release both lines and pulse tx_error, then return to IDLE. With PS2_TX_RETRY_EN, see Optional Feature.
- busy=1 in every state except IDLE.
- A tx_valid seen while busy is ignored; there is no queue.
- Reset mid-transfer releases both lines within the same reset assertion (asynchronous), and no done/error pulse is generated.
- The parity bit always makes the 9-bit data+parity count odd (e.g. 0xED gives parity 1, 0xF4 gives parity 0).
- Counter width must hold START_TMO_CYC (21 bits).

Optional Feature:
- PS2_TX_RETRY_EN defined: FAIL with retry_cnt < MAX_RETRY increments retry_cnt and re-enters INHIBIT using the same frame.
  - busy stays 1 and no tx_error pulse is generated.
  - tx_error pulses only after the last retry fails.
- Undefined: FAIL always pulses tx_error and returns to IDLE immediately. retry_cnt is not built.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, RTS, WAIT_CLK, SHIFT, ACK, WAIT_IDLE, FAIL;
  - command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA;
  - FRAME_BITS=10.
- One natural sub-module, ps2_line_sync: the 2-FF synchronizer plus falling-edge detect. It is also reusable by the keyboard receive path.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that acks: clk is held low ≥12000 cycles, then data goes low and clk is released. Shifted bits are 1,0,1,1,0,1,1,1, parity 1, stop 1. Ack gives one tx_done pulse. busy returns to 0 after both lines read high.
- Send 0xF4: the device model reconstructs byte 0xF4 with parity bit 0 and reports no framing error. tx_done fires.
- Device never clocks: tx_error pulses exactly START_TMO_CYC cycles after RTS ends (retry macro off). Both oe outputs are 0.
- Device holds data high on the 11th clock (nack): macro off gives one tx_error. Macro on with MAX_RETRY=2 gives 3 inhibit sequences then one tx_error. Macro on with a nack on the 1st attempt only gives 2 sequences then tx_done.
- reset=0 asserted during SHIFT at bit 4: ps2_clk_oe and ps2_data_oe drop to 0 immediately, with no pulses. After release, tx_ready=1 and a new 0xFF transfer completes.
- A tx_valid pulse while busy with a different byte: the frame of the first byte is unchanged and only one transfer occurs.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command codes and frame helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_CLK,
        SHIFT,
        ACK,
        WAIT_IDLE,
        FAIL
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

    localparam int FRAME_BITS = 10;

    // Wide enough for the longest wait (the 15 ms start timeout at 100 MHz).
    localparam int CNT_W = 21;

    // Bits shifted after the start bit: data LSB first, odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 line synchronizer with clock falling-edge detect
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Two-stage synchronizers; idle bus level is high, so reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_in};
            data_ff  <= {data_ff[0], data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign fall      = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (optional retry: PS2_TX_RETRY_EN)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC   = 12000,
    parameter int START_TMO_CYC = 1500000,
`ifdef PS2_TX_RETRY_EN
    parameter int MAX_RETRY     = 2,
`endif
    parameter int PKT_TMO_CYC   = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    ps2_tx_state_t         state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [FRAME_BITS-1:0] frame, frame_n;
    logic                  clk_oe, clk_oe_n;
    logic                  data_oe, data_oe_n;
    logic                  ack_bit, ack_bit_n;
    logic                  clk_s, data_s, fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_s),
        .data_sync (data_s),
        .fall      (fall)
    );

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_cnt, retry_cnt_n;

    // Attempt counter, cleared when a new byte is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retry_cnt <= '0;
        else        retry_cnt <= retry_cnt_n;
    end
`endif

    // State, timers, frame and line drivers; the oe lines are registered so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            ack_bit <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            frame   <= frame_n;
            clk_oe  <= clk_oe_n;
            data_oe <= data_oe_n;
            ack_bit <= ack_bit_n;
        end
    end

    // Next-state logic; cnt times inhibit, start wait and then the whole packet.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        clk_oe_n  = clk_oe;
        data_oe_n = data_oe;
        ack_bit_n = ack_bit;
        tx_done   = 1'b0;
        tx_error  = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_cnt_n = retry_cnt;
`endif
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    frame_n   = ps2_frame(tx_data);
                    cnt_n     = '0;
                    clk_oe_n  = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_cnt_n = '0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = RTS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RTS: begin
                clk_oe_n = 1'b0;
                cnt_n    = '0;
                state_n  = WAIT_CLK;
            end
            WAIT_CLK: begin
                if (fall) begin
                    data_oe_n = ~frame[0];
                    bit_cnt_n = 4'd1;
                    cnt_n     = '0;
                    state_n   = SHIFT;
                end else if (cnt == CNT_W'(START_TMO_CYC - 1)) begin
                    state_n = FAIL;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_W'(PKT_TMO_CYC - 1)) begin
                    state_n = FAIL;
                end else if (fall) begin
                    if (bit_cnt == 4'(FRAME_BITS)) begin
                        ack_bit_n = data_s;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = ~frame[bit_cnt];
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ACK: begin
                data_oe_n = 1'b0;
                state_n   = ack_bit ? FAIL : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    tx_done = 1'b1;
                    state_n = IDLE;
                end
            end
            FAIL: begin
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                    retry_cnt_n = retry_cnt + 1'b1;
                    cnt_n       = '0;
                    clk_oe_n    = 1'b1;
                    state_n     = INHIBIT;
                end else begin
                    tx_error = 1'b1;
                    state_n  = IDLE;
                end
`else
                tx_error = 1'b1;
                state_n  = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        // Both lines are already released while FAIL reports the error.
        if (state_n == FAIL) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
        end
    end

    assign ps2_clk_oe  = clk_oe;
    assign ps2_data_oe = data_oe;
    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);

endmodule
